cube_frame_accumulator: RTL and testbench

Downstream consumer of the 8-bit cube (X³) pipeline stage. Accepts one cube result per cycle over a valid/ready handshake, sums a fixed-length frame of N samples with saturation, and presents each frame total on a held valid/ready output port. Includes a synchronous flush and a wrapping frame index for traceability.

---
 rtl/cube_frame_accumulator.sv | 131 +++++++++++++
 tb/tb_cube_frame_accumulator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_frame_accumulator.sv
// Sums fixed-length frames of unsigned cube results with saturation.
// Each frame total is held on a valid/ready output port.
module cube_frame_accumulator #(
    parameter int DATA_W = 8,
    parameter int N      = 4,
    parameter int ACC_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic [7:0]        out_frame,
    output logic              state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are
    // both high; valid never waits on ready, and a held result stays stable
    // until its transfer.
    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [7:0]       cnt;
    logic [7:0]       frame;

    logic             accept;
    logic             last;
    logic             release_hold;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_sat;
    logic             ovf_nxt;

    // Any bit at or above ACC_W in the widened sum means the true sum overflowed.
    assign sum_ext = {1'b0, acc} + (ACC_W + 1)'(in_data);
    assign sum_sat = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
    assign ovf_nxt = ovf | sum_ext[ACC_W];

    assign out_valid = (state == HOLD);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        accept       = 1'b0;
        last         = 1'b0;
        release_hold = 1'b0;
        if (flush) begin
            state_nxt = ACC;
        end else begin
            case (state)
                ACC: begin
                    in_ready = 1'b1;
                    accept   = in_valid;
                    if (in_valid && (cnt == LAST_CNT)) begin
                        last      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    in_ready = out_ready;
                    if (out_ready) begin
                        release_hold = 1'b1;
                        accept       = in_valid;
                        state_nxt    = ACC;
                    end
                end
                default: state_nxt = ACC;
            endcase
        end
        if (!rst_n) begin
            in_ready = 1'b0;
        end
    end

    // acc/ovf/cnt are already clear in HOLD, so a sample accepted alongside
    // the output handshake simply becomes the first sample of the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            frame     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_frame <= '0;
        end else if (flush) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else begin
            if (release_hold) begin
                frame <= frame + 8'd1;
            end
            if (accept) begin
                if (last) begin
                    out_sum   <= sum_sat;
                    out_ovf   <= ovf_nxt;
                    out_frame <= frame;
                    acc       <= '0;
                    ovf       <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_sat;
                    ovf <= ovf_nxt;
                    cnt <= cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cube_frame_accumulator.sv
// Bench for cube_frame_accumulator: a 10-bit and a 9-bit accumulator share one
// stimulus stream and are compared against a frame-level sum model.
module tb_cube_frame_accumulator;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       in_ready, out_valid, out_ovf, st;
    logic [9:0] out_sum;
    logic [7:0] out_frame;
    logic       in_ready9, out_valid9, out_ovf9, st9;
    logic [8:0] out_sum9;
    logic [7:0] out_frame9;

    cube_frame_accumulator #(.DATA_W(8), .N(N), .ACC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf),
        .out_frame(out_frame), .state_dbg(st)
    );

    cube_frame_accumulator #(.DATA_W(8), .N(N), .ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready9), .in_data(in_data), .out_valid(out_valid9),
        .out_ready(out_ready), .out_sum(out_sum9), .out_ovf(out_ovf9),
        .out_frame(out_frame9), .state_dbg(st9)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endfunction

    // Reference model: the samples of the open frame, plus the last presented result.
    int         samples[$];
    logic [9:0] exp_q[$];
    bit         m_hold;
    int         m_frame, m_oframe;
    int         m_sum10, m_sum9;
    bit         m_ovf10, m_ovf9;
    bit         ir_seen;

    function automatic void model_reset();
        samples.delete();
        exp_q.delete();
        m_hold   = 0;
        m_frame  = 0;
        m_oframe = 0;
        m_sum10  = 0;
        m_sum9   = 0;
        m_ovf10  = 0;
        m_ovf9   = 0;
    endfunction

    function automatic void check_outputs(string tag);
        check({tag, "_out_valid"}, out_valid, m_hold);
        check({tag, "_out_valid9"}, out_valid9, m_hold);
        check({tag, "_out_sum"}, out_sum, m_sum10);
        check({tag, "_out_sum9"}, out_sum9, m_sum9);
        check({tag, "_out_ovf"}, out_ovf, m_ovf10);
        check({tag, "_out_ovf9"}, out_ovf9, m_ovf9);
        check({tag, "_out_frame"}, out_frame, m_oframe);
        check({tag, "_out_frame9"}, out_frame9, m_oframe);
    endfunction

    task automatic step(input bit f, input bit iv, input int d, input bit ordy);
        bit exp_ir;
        bit acc_ok;
        int total;
        @(negedge clk);
        flush     = f;
        in_valid  = iv;
        in_data   = 8'(d);
        out_ready = ordy;
        #1;
        exp_ir  = !f && (!m_hold || ordy);
        ir_seen = in_ready;
        check("in_ready", in_ready, exp_ir);
        check("in_ready9", in_ready9, exp_ir);
        if (!f && m_hold && ordy) begin
            check("handshake_sum", out_sum, exp_q.pop_front());
        end
        acc_ok = iv && exp_ir;
        @(posedge clk);
        if (f) begin
            if (m_hold) void'(exp_q.pop_front());
            samples.delete();
            m_hold = 0;
        end else begin
            if (m_hold && ordy) begin
                m_hold  = 0;
                m_frame = (m_frame + 1) % 256;
            end
            if (acc_ok) begin
                samples.push_back(d);
                if (samples.size() == N) begin
                    total = 0;
                    foreach (samples[i]) total += samples[i];
                    m_sum10  = (total > 1023) ? 1023 : total;
                    m_ovf10  = (total > 1023);
                    m_sum9   = (total > 511) ? 511 : total;
                    m_ovf9   = (total > 511);
                    m_oframe = m_frame;
                    m_hold   = 1;
                    samples.delete();
                    exp_q.push_back(10'(m_sum10));
                end
            end
        end
        #1;
        check_outputs("model");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #1;
        check("reset_in_ready", in_ready, 0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit f, iv;
        int d;
        bit ordy;
        bit e_ir, e_ov;
        int e_sum;
        bit e_ovf;
        int e_frame;
    } vec_t;

    vec_t tbl[11];
    int   results;

    initial begin
        tbl[0]  = '{0, 1, 1,  1, 1, 0, 0,   0, 0};
        tbl[1]  = '{0, 1, 8,  1, 1, 0, 0,   0, 0};
        tbl[2]  = '{0, 1, 27, 1, 1, 0, 0,   0, 0};
        tbl[3]  = '{0, 1, 64, 1, 1, 1, 100, 0, 0};
        tbl[4]  = '{0, 0, 0,  1, 1, 0, 0,   0, 0};
        tbl[5]  = '{0, 1, 1,  0, 1, 0, 0,   0, 0};
        tbl[6]  = '{0, 1, 1,  0, 1, 0, 0,   0, 0};
        tbl[7]  = '{0, 1, 1,  0, 1, 0, 0,   0, 0};
        tbl[8]  = '{0, 1, 1,  0, 1, 1, 4,   0, 1};
        tbl[9]  = '{0, 0, 0,  0, 0, 1, 4,   0, 1};
        tbl[10] = '{0, 0, 0,  1, 1, 0, 0,   0, 0};

        rst_n = 1'b0;
        do_reset();

        // Basic frames from a fixed table.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].f, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            check($sformatf("tbl%0d_in_ready", i), ir_seen, tbl[i].e_ir);
            check($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
            if (tbl[i].e_ov) begin
                check($sformatf("tbl%0d_out_sum", i), out_sum, tbl[i].e_sum);
                check($sformatf("tbl%0d_out_ovf", i), out_ovf, tbl[i].e_ovf);
                check($sformatf("tbl%0d_out_frame", i), out_frame, tbl[i].e_frame);
            end
        end

        // Saturation in the 9-bit instance, then a clean frame right behind it.
        for (int i = 0; i < 4; i++) step(0, 1, 255, 1);
        check("sat9_sum", out_sum9, 511);
        check("sat9_ovf", out_ovf9, 1);
        check("sat10_sum", out_sum, 1020);
        check("sat10_ovf", out_ovf, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1);
        check("after_sat9_sum", out_sum9, 4);
        check("after_sat9_ovf", out_ovf9, 0);
        step(0, 0, 0, 1);

        // Backpressure: the result is held and no samples enter.
        for (int i = 1; i <= 4; i++) step(0, 1, i * 10, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 99, 0);
            check("bp_in_ready", ir_seen, 0);
            check("bp_out_sum", out_sum, 100);
        end
        step(0, 1, 7, 1);
        check("bp_release_valid", out_valid, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0);
        check("bp_next_frame_sum", out_sum, 10);
        step(0, 0, 0, 1);

        // Sustained stream with the output always ready.
        results = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 2, 1);
            check("stream_in_ready", ir_seen, 1);
            if (out_valid) begin
                check("stream_sum", out_sum, 8);
                results++;
            end
        end
        check("stream_results", results, 3);
        step(0, 0, 0, 1);

        // Flush drops a partial frame and the offered sample.
        step(0, 1, 5, 1);
        step(0, 1, 5, 1);
        step(1, 1, 9, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 3, 1);
        check("flush_sum", out_sum, 12);
        step(1, 0, 0, 1);
        check("flush_hold_discarded", out_valid, 0);

        // Asynchronous reset in the middle of HOLD.
        for (int i = 0; i < 4; i++) step(0, 1, 6, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_in_ready", in_ready, 0);
        check_outputs("async_reset");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step(0, 1, 3, 1);
        check("post_reset_frame", out_frame, 0);
        check("post_reset_valid", out_valid, 1);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 255)), $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
